// File: rtl/key_debounce_pulse.sv
// Debounces an active-low mechanical key and emits one-cycle strobes on each
// accepted press and, optionally, auto-repeat strobes while the key is held.
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic sclk,
  input  logic rst,
  input  logic key_n,
  output logic key_pulse,
  output logic key_level
);

  localparam int MAX_AB     = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REPEAT,
    REL_CHK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             s1;
  logic             s2;
  logic             key_sync;
  logic             pulse_nxt;
  logic             level_nxt;

  // key_n is asynchronous; only s1 ever samples it. Reset value 1 = released.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  assign key_sync = s2;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_pulse <= 1'b0;
      key_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_pulse <= pulse_nxt;
      key_level <= level_nxt;
    end
  end

  // One shared counter times debounce, long-press and repeat intervals.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (!key_sync) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (key_sync) begin
          state_nxt = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (key_sync) begin
          state_nxt = REL_CHK;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          if (REPEAT_EN) begin
            state_nxt = REPEAT;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (key_sync) begin
          state_nxt = REL_CHK;
          cnt_nxt   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REL_CHK: begin
        // A low glitch while releasing means still held; long-press restarts.
        if (!key_sync) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    pulse_nxt = 1'b0;
    level_nxt = key_level;
    case (state)
      PRESS_CHK: begin
        if (!key_sync && cnt == DEB_LAST) begin
          pulse_nxt = 1'b1;
          level_nxt = 1'b1;
        end
      end
      HELD: begin
        if (!key_sync && REPEAT_EN && cnt == LONG_LAST) begin
          pulse_nxt = 1'b1;
        end
      end
      REPEAT: begin
        if (!key_sync && cnt == REP_LAST) begin
          pulse_nxt = 1'b1;
        end
      end
      REL_CHK: begin
        if (key_sync && cnt == DEB_LAST) begin
          level_nxt = 1'b0;
        end
      end
      default: begin
        pulse_nxt = 1'b0;
      end
    endcase
  end

  // Cycle counts below 2 would let strobes merge or counters underflow.
  always_ff @(posedge sclk) begin
    assert (DEBOUNCE_CYCLES >= 2 && LONG_CYCLES >= 2 && REPEAT_CYCLES >= 2)
      else $error("key_debounce_pulse: cycle parameters must be >= 2");
  end

endmodule

// File: doc/key_debounce_pulse.md
KEY_DEBOUNCE_PULSE -- requirements
Module: key_debounce_pulse

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the stable-level cycles required to accept a press or a release (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 50_000_000, meaning the cycles from the first pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 10_000_000, meaning the auto-repeat pulse period in cycles.
REQ-004 The block SHALL have parameter REPEAT_EN, default 1, meaning 1 enables auto-repeat and 0 gives a single pulse per press.
REQ-005 The block SHALL have port sclk, input, 1 bit, the single system clock; all flops are on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-007 The block SHALL have port key_n, input, 1 bit: the raw mechanical key, active-low, asynchronous to sclk, and bouncing.
REQ-008 The block SHALL have port key_pulse, output reg, 1 bit: a one-cycle strobe per accepted press or repeat, and it drives the downstream counter's key_add input.
REQ-009 The block SHALL have port key_level, output reg, 1 bit: the debounced key state, where 1 means pressed.

Function
REQ-010 The block SHALL pass key_n through a 2-flop synchroniser (s1 then s2); key_sync is s2, and no other logic samples key_n.
REQ-011 The block SHALL use FSM states IDLE, PRESS_CHK, HELD, REPEAT and REL_CHK, together with a single shared counter cnt.
REQ-012 In IDLE, key_sync=0 SHALL cause a move to PRESS_CHK with cnt<=0; otherwise the FSM stays in IDLE.
REQ-013 In PRESS_CHK, key_sync=1 SHALL cause a return to IDLE (bounce rejected); if cnt==DEBOUNCE_CYCLES-1 the FSM moves to HELD with cnt<=0, key_pulse<=1 and key_level<=1; otherwise cnt increments.
REQ-014 Press latency SHALL be as follows: key_pulse is high in the cycle after the (DEBOUNCE_CYCLES+3)th rising edge, counting the edge at which s1 first samples 0.
REQ-015 In HELD, key_sync=1 SHALL cause a move to REL_CHK with cnt<=0; if REPEAT_EN=1 and cnt==LONG_CYCLES-1, the FSM moves to REPEAT with cnt<=0 and key_pulse<=1; otherwise cnt increments.
REQ-016 With REPEAT_EN=0, HELD SHALL never exit except via release, and cnt saturates at LONG_CYCLES-1 with no wrap.
REQ-017 In REPEAT, key_sync=1 SHALL cause a move to REL_CHK with cnt<=0; if cnt==REPEAT_CYCLES-1, key_pulse<=1 and cnt<=0; otherwise cnt increments.
REQ-018 In REL_CHK, key_sync=0 SHALL cause a move to HELD with cnt<=0 (release bounce rejected; long-press timing restarts); if cnt==DEBOUNCE_CYCLES-1 the FSM moves to IDLE with key_level<=0; otherwise cnt increments.
REQ-019 key_pulse SHALL be 0 in every cycle not named in REQ-013, REQ-015 and REQ-017, and it is never high for 2 consecutive cycles.
REQ-020 key_level SHALL change only on the transitions PRESS_CHK->HELD and REL_CHK->IDLE.
REQ-021 cnt width SHALL be $clog2 of the largest of the three cycle parameters, and no counter wraps at any boundary.
REQ-022 Every cycle parameter SHALL be >=2; smaller values are illegal and are flagged by a simulation-time assertion.
REQ-023 An undefined state SHALL recover to IDLE on the next edge with key_pulse=0.

Reset
REQ-024 While rst=1 the block SHALL hold state IDLE, cnt=0, s1=s2=1 (released), key_pulse=0 and key_level=0.
REQ-025 rst asserted mid-press or mid-repeat SHALL abort immediately with no pulse emitted; after release of rst, a still-held key is re-debounced from IDLE and yields a fresh pulse.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3)
REQ-026 Clean press at edge 1, held for 12 edges -> key_pulse high exactly after edge 7 only; key_level rises after edge 7.
REQ-027 Press with 2-cycle bounce pulses (low 2, high 1, low held) -> exactly one key_pulse, occurring 7 edges after the final falling edge.
REQ-028 Press held for 30 edges -> pulses after edges 7, 17, 20, 23, 26, 29 and no others.
REQ-029 Same stimulus as REQ-028 with REPEAT_EN=0 -> single pulse after edge 7.
REQ-030 Release with a 1-cycle low glitch during REL_CHK -> key_level stays 1 and no pulse; a clean release drops key_level 7 edges after the rise.
REQ-031 rst pulsed at edge 5 of a press -> no pulse and both outputs 0; key held through rst release -> one pulse 7 edges after the rst deassertion edge.
